conv_tap_scheduler: RTL and testbench

- Sequencer for one shared multiply-accumulate (MAC) datapath that computes a full valid-mode 2-D convolution: an IDim x IDim image with an FDim x FDim filter, stride 1.
- Walks the output positions in raster order. For each position it issues FDim*FDim tap addresses to the MAC, waits for the MAC result, then emits one output write.
- Sits between the layer-level start/done control and the image/filter memories, the MAC and the output feature-map memory.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_tap_scheduler_if.sv | 45 ++++
 rtl/conv_tap_counter.sv | 48 ++++
 rtl/conv_tap_scheduler.sv | 148 ++++++++++++++
 tb/tb_conv_tap_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : conv_pkg                                                          |
// | Brief  : Shared types and default geometry for the convolution datapath.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package conv_pkg;

  localparam int C_FDIM       = 5;
  localparam int C_IDIM       = 32;
  localparam int C_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_RES = 3'd2,
    ST_WRITE    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_tap_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : conv_tap_scheduler_if                                             |
// | Brief  : Tap, MAC-result and output-write bus of the tap scheduler.        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface conv_tap_scheduler_if #(
  parameter int FDim       = conv_pkg::C_FDIM,
  parameter int IDim       = conv_pkg::C_IDIM,
  parameter int DATA_WIDTH = conv_pkg::C_DATA_WIDTH
);
  localparam int AW = $clog2(IDim);
  localparam int FW = $clog2(FDim);

  logic [AW-1:0]         img_row;
  logic [AW-1:0]         img_col;
  logic [FW-1:0]         flt_row;
  logic [FW-1:0]         flt_col;
  logic                  tap_valid;
  logic                  tap_first;
  logic                  tap_last;
  logic                  tap_ready;
  logic                  res_valid;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  out_we;
  logic [AW-1:0]         out_row;
  logic [AW-1:0]         out_col;
  logic [DATA_WIDTH-1:0] out_data;

  // Scheduler side
  modport master (
    output img_row, img_col, flt_row, flt_col, tap_valid, tap_first, tap_last,
    input  tap_ready, res_valid, res_data,
    output out_we, out_row, out_col, out_data
  );

  // MAC / memory side
  modport slave (
    input  img_row, img_col, flt_row, flt_col, tap_valid, tap_first, tap_last,
    output tap_ready, res_valid, res_data,
    input  out_we, out_row, out_col, out_data
  );

endinterface
`default_nettype wire

// File: rtl/conv_tap_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : conv_tap_counter                                                  |
// | Brief  : m/n filter-tap counter walking one FDim x FDim window row-major.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module conv_tap_counter #(
  parameter int FDim = conv_pkg::C_FDIM,
  parameter int FW   = $clog2(FDim)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          clear,
  input  wire logic          advance,
  output logic      [FW-1:0] m,
  output logic      [FW-1:0] n,
  output logic               first,
  output logic               last,
  output logic               wrap
);
  localparam logic [FW-1:0] C_LAST = FW'(FDim - 1);

  logic [FW-1:0] r_m;
  logic [FW-1:0] r_n;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_m <= '0;
      r_n <= '0;
    end else if (advance) begin
      if (r_n == C_LAST) begin
        r_n <= '0;
        r_m <= (r_m == C_LAST) ? '0 : r_m + FW'(1);
      end else begin
        r_n <= r_n + FW'(1);
      end
    end
  end

  assign m     = r_m;
  assign n     = r_n;
  assign first = (r_m == '0) && (r_n == '0);
  assign last  = (r_m == C_LAST) && (r_n == C_LAST);
  // Counter returns to 0/0 on this same edge, ready for the next window.
  assign wrap  = advance && last;

endmodule
`default_nettype wire

// File: rtl/conv_tap_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : conv_tap_scheduler                                                |
// | Brief  : Raster-order output walker issuing filter taps to a shared MAC.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module conv_tap_scheduler
  import conv_pkg::*;
#(
  parameter int FDim       = C_FDIM,
  parameter int IDim       = C_IDIM,
  parameter int DATA_WIDTH = C_DATA_WIDTH
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             start,
  output logic                  busy,
  output logic                  done,
  conv_tap_scheduler_if.master  bus
);
  localparam int ODim = IDim - FDim + 1;
  localparam int AW   = $clog2(IDim);
  localparam int FW   = $clog2(FDim);

  localparam logic [AW-1:0] C_OLAST = AW'(ODim - 1);

  state_t                r_state;
  logic [AW-1:0]         r_i;
  logic [AW-1:0]         r_j;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_tap_valid;
  logic                  r_out_we;
  logic [AW-1:0]         r_out_row;
  logic [AW-1:0]         r_out_col;
  logic [DATA_WIDTH-1:0] r_out_data;

  logic [FW-1:0] w_m;
  logic [FW-1:0] w_n;
  logic          w_first;
  logic          w_last;
  logic          w_wrap;
  logic          w_xfer;
  logic          w_clear;

  assign w_xfer  = r_tap_valid && bus.tap_ready;
  assign w_clear = (r_state == ST_IDLE) && start;

  conv_tap_counter #(
    .FDim (FDim),
    .FW   (FW)
  ) u_tap_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_clear),
    .advance (w_xfer),
    .m       (w_m),
    .n       (w_n),
    .first   (w_first),
    .last    (w_last),
    .wrap    (w_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_i         <= '0;
      r_j         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_tap_valid <= 1'b0;
      r_out_we    <= 1'b0;
      r_out_row   <= '0;
      r_out_col   <= '0;
      r_out_data  <= '0;
    end else begin
      r_done   <= 1'b0;
      r_out_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_ISSUE;
            r_busy      <= 1'b1;
            r_tap_valid <= 1'b1;
            r_i         <= '0;
            r_j         <= '0;
          end
        end
        ST_ISSUE: begin
          if (w_wrap) begin
            r_state     <= ST_WAIT_RES;
            r_tap_valid <= 1'b0;
          end
        end
        ST_WAIT_RES: begin
          if (bus.res_valid) begin
            r_state    <= ST_WRITE;
            r_out_we   <= 1'b1;
            r_out_row  <= r_i;
            r_out_col  <= r_j;
            r_out_data <= bus.res_data;
          end
        end
        ST_WRITE: begin
          if ((r_i == C_OLAST) && (r_j == C_OLAST)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_i     <= '0;
            r_j     <= '0;
          end else begin
            r_state     <= ST_ISSUE;
            r_tap_valid <= 1'b1;
            if (r_j == C_OLAST) begin
              r_j <= '0;
              r_i <= r_i + AW'(1);
            end else begin
              r_j <= r_j + AW'(1);
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // m/n sit at 0 outside ISSUE, so the image address tracks i/j there.
  assign bus.img_row   = r_i + AW'(w_m);
  assign bus.img_col   = r_j + AW'(w_n);
  assign bus.flt_row   = w_m;
  assign bus.flt_col   = w_n;
  assign bus.tap_valid = r_tap_valid;
  assign bus.tap_first = r_tap_valid && w_first;
  assign bus.tap_last  = r_tap_valid && w_last;
  assign bus.out_we    = r_out_we;
  assign bus.out_row   = r_out_row;
  assign bus.out_col   = r_out_col;
  assign bus.out_data  = r_out_data;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_tap_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_conv_tap_scheduler                                             |
// | Brief  : Directed self-checking bench: 3x3 on 5x5 runs plus 5x5 on 32x32.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_conv_tap_scheduler;

  typedef struct {
    logic [2:0]  r;
    logic [2:0]  c;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_s = 1'b0;
  logic start_f = 1'b0;
  logic busy_s, done_s, busy_f, done_f;

  logic        bp = 1'b0;
  logic        stray_rv = 1'b0;
  logic        mac_s_rv = 1'b0;
  logic [31:0] mac_s_rd = '0;
  logic        mac_f_rv = 1'b0;
  logic [31:0] mac_f_rd = '0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  // small-instance observations
  logic [11:0] tap_q[$];
  wr_t         wr_q[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          stab_err = 0;

  // full-size observations
  int wr_f = 0, bad_f = 0, done_f_cnt = 0, done_f_cyc = 0, last_wr_cyc = 0;
  int last_row_f = -1, last_col_f = -1;

  conv_tap_scheduler_if #(.FDim(3), .IDim(5),  .DATA_WIDTH(32)) bs ();
  conv_tap_scheduler_if #(.FDim(5), .IDim(32), .DATA_WIDTH(32)) bf ();

  conv_tap_scheduler #(.FDim(3), .IDim(5), .DATA_WIDTH(32)) u_dut_s (
    .clk (clk), .rst (rst), .start (start_s), .busy (busy_s), .done (done_s), .bus (bs)
  );

  conv_tap_scheduler #(.FDim(5), .IDim(32), .DATA_WIDTH(32)) u_dut_f (
    .clk (clk), .rst (rst), .start (start_f), .busy (busy_f), .done (done_f), .bus (bf)
  );

  assign bs.res_valid = mac_s_rv | stray_rv;
  assign bs.res_data  = stray_rv ? 32'hDEAD_BEEF : mac_s_rd;
  assign bf.tap_ready = 1'b1;
  assign bf.res_valid = mac_f_rv;
  assign bf.res_data  = mac_f_rd;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // tap_ready: constant 1, or toggling every cycle under backpressure
  initial begin
    bs.tap_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bs.tap_ready = bp ? ~bs.tap_ready : 1'b1;
    end
  end

  // Small MAC: counts taps, result 2 cycles after the last-tap transfer
  initial begin
    int cd;
    int acc;
    cd = 0; acc = 0;
    forever begin
      @(negedge clk);
      mac_s_rv = 1'b0;
      if (rst) begin
        cd = 0; acc = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin mac_s_rv = 1'b1; mac_s_rd = 32'(acc); end
        end
        if (bs.tap_valid && bs.tap_ready) begin
          acc = bs.tap_first ? 1 : acc + 1;
          if (bs.tap_last) cd = 2;
        end
      end
    end
  end

  // Full MAC: image=1, filter=2, result 1 cycle after the last-tap transfer
  initial begin
    int cd;
    int acc;
    cd = 0; acc = 0;
    forever begin
      @(negedge clk);
      mac_f_rv = 1'b0;
      if (rst) begin
        cd = 0; acc = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin mac_f_rv = 1'b1; mac_f_rd = 32'(acc); end
        end
        if (bf.tap_valid && bf.tap_ready) begin
          acc = bf.tap_first ? 2 : acc + 2;
          if (bf.tap_last) cd = 1;
        end
      end
    end
  end

  // Monitors
  initial begin
    logic        prev_stall;
    logic [11:0] prev_tap;
    logic [11:0] cur;
    prev_stall = 1'b0; prev_tap = '0;
    forever begin
      @(negedge clk);
      cur = {bs.img_row, bs.img_col, bs.flt_row, bs.flt_col, bs.tap_first, bs.tap_last};
      if (prev_stall && (!bs.tap_valid || cur != prev_tap)) stab_err++;
      prev_stall = bs.tap_valid && !bs.tap_ready;
      prev_tap   = cur;
      if (bs.tap_valid && bs.tap_ready) tap_q.push_back(cur);
      if (bs.out_we) wr_q.push_back('{bs.out_row, bs.out_col, bs.out_data});
      if (done_s) begin done_cnt++; done_cyc = cyc; end
      if (bf.out_we) begin
        wr_f++;
        if (bf.out_data != 32'd50) bad_f++;
        last_row_f  = int'(bf.out_row);
        last_col_f  = int'(bf.out_col);
        last_wr_cyc = cyc;
      end
      if (done_f) begin done_f_cnt++; done_f_cyc = cyc; end
    end
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [11:0] exp_tap(input int k);
    int p, t, i, j, m, n;
    p = k / 9; t = k % 9;
    i = p / 3; j = p % 3; m = t / 3; n = t % 3;
    return {3'(i + m), 3'(j + n), 2'(m), 2'(n), (t == 0), (t == 8)};
  endfunction

  task automatic clear_logs();
    tap_q.delete();
    wr_q.delete();
    done_cnt = 0;
    stab_err = 0;
  endtask

  task automatic start_small();
    @(posedge clk);
    #1 start_s = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1 start_s = 1'b0;
  endtask

  task automatic wait_done_s(input string tag, input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin @(negedge clk); k++; end
    if (done_cnt == 0) check_eq({tag, "_timeout"}, 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_taps(input string tag);
    int bad;
    bad = 0;
    check_eq({tag, "_tap_count"}, tap_q.size(), 81);
    for (int k = 0; k < 81 && k < tap_q.size(); k++)
      if (tap_q[k] != exp_tap(k)) bad++;
    check_eq({tag, "_tap_seq_errs"}, bad, 0);
  endtask

  task automatic check_writes(input string tag);
    int bad;
    bad = 0;
    check_eq({tag, "_write_count"}, wr_q.size(), 9);
    for (int k = 0; k < 9 && k < wr_q.size(); k++)
      if (wr_q[k].r != 3'(k / 3) || wr_q[k].c != 3'(k % 3) || wr_q[k].d != 32'd9) bad++;
    check_eq({tag, "_write_errs"}, bad, 0);
  endtask

  initial begin
    int k;
    int cnt11;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy",      busy_s, 0);
    check_eq("rst_done",      done_s, 0);
    check_eq("rst_tap_valid", bs.tap_valid, 0);
    check_eq("rst_tap_first", bs.tap_first, 0);
    check_eq("rst_out_we",    bs.out_we, 0);
    check_eq("rst_out_data",  bs.out_data, 0);
    check_eq("rst_img_addr",  {bs.img_row, bs.img_col}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Counting run
    clear_logs();
    start_small();
    wait_done_s("count", 400);
    check_taps("count");
    check_writes("count");
    check_eq("count_tap0",       tap_q[0], exp_tap(0));
    check_eq("count_tap8",       tap_q[8], {3'd2, 3'd2, 2'd2, 2'd2, 1'b0, 1'b1});
    check_eq("count_done_pulses", done_cnt, 1);
    check_eq("count_done_latency", done_cyc - start_cyc, 109);
    check_eq("count_idle_busy",  busy_s, 0);

    // Backpressure
    clear_logs();
    bp = 1'b1;
    start_small();
    wait_done_s("bp", 800);
    bp = 1'b0;
    check_eq("bp_stall_unstable", stab_err, 0);
    check_taps("bp");
    check_writes("bp");

    // Start while busy
    clear_logs();
    start_small();
    while (cyc < start_cyc + 3) @(posedge clk);
    #1 start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    while (cyc < start_cyc + 20) @(posedge clk);
    #1 start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    wait_done_s("sbusy", 400);
    repeat (20) @(negedge clk);
    check_eq("sbusy_done_pulses", done_cnt, 1);
    check_writes("sbusy");
    check_eq("sbusy_idle_busy", busy_s, 0);

    // Mid-window reset at tap 4 of window (1,1)
    clear_logs();
    start_small();
    k = 0;
    do begin
      @(negedge clk); k++;
    end while (!(bs.tap_valid && bs.img_row == 3'd2 && bs.img_col == 3'd2 &&
                 bs.flt_row == 2'd1 && bs.flt_col == 2'd1) && k < 200);
    check_eq("mrst_found_tap4", k < 200, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mrst_busy",      busy_s, 0);
    check_eq("mrst_tap_valid", bs.tap_valid, 0);
    check_eq("mrst_tap_first", bs.tap_first, 0);
    check_eq("mrst_out_we",    bs.out_we, 0);
    check_eq("mrst_out_data",  bs.out_data, 0);
    check_eq("mrst_out_addr",  {bs.out_row, bs.out_col}, 0);
    check_eq("mrst_tap_addr",  {bs.img_row, bs.img_col, bs.flt_row, bs.flt_col}, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    cnt11 = 0;
    foreach (wr_q[q]) if (wr_q[q].r == 3'd1 && wr_q[q].c == 3'd1) cnt11++;
    check_eq("mrst_no_write_11", cnt11, 0);
    check_eq("mrst_writes_before", wr_q.size(), 4);
    clear_logs();
    start_small();
    wait_done_s("mrst_rerun", 400);
    check_eq("mrst_rerun_tap0", tap_q[0], {3'd0, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0});
    check_writes("mrst_rerun");

    // Stray result in IDLE
    clear_logs();
    @(negedge clk);
    stray_rv = 1'b1;
    @(negedge clk);
    stray_rv = 1'b0;
    check_eq("stray_idle_out_we", bs.out_we, 0);
    check_eq("stray_idle_busy",   busy_s, 0);
    repeat (3) @(negedge clk);
    check_eq("stray_idle_writes", wr_q.size(), 0);
    check_eq("stray_idle_data",   bs.out_data, 9);

    // Stray result in ISSUE
    clear_logs();
    start_small();
    repeat (2) @(negedge clk);
    check_eq("stray_issue_pre_valid", bs.tap_valid, 1);
    stray_rv = 1'b1;
    @(negedge clk);
    stray_rv = 1'b0;
    check_eq("stray_issue_out_we", bs.out_we, 0);
    check_eq("stray_issue_valid",  bs.tap_valid, 1);
    wait_done_s("stray_issue", 400);
    check_taps("stray_issue");
    check_writes("stray_issue");

    // Full-size smoke
    @(posedge clk);
    #1 start_f = 1'b1;
    @(posedge clk);
    #1 start_f = 1'b0;
    k = 0;
    while (done_f_cnt == 0 && k < 25000) begin @(negedge clk); k++; end
    if (done_f_cnt == 0) check_eq("full_timeout", 0, 1);
    repeat (3) @(negedge clk);
    check_eq("full_writes",     wr_f, 784);
    check_eq("full_bad_data",   bad_f, 0);
    check_eq("full_last_row",   last_row_f, 27);
    check_eq("full_last_col",   last_col_f, 27);
    check_eq("full_done_pulses", done_f_cnt, 1);
    check_eq("full_done_after_last", done_f_cyc - last_wr_cyc, 1);
    check_eq("full_idle_busy",  busy_f, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
